// File: rtl/led_status_sched_if.sv
// led_status_sched_if: event and display signals between status sources and the LED scheduler
//  evt       per-source 1-cycle event strobe
//  evt_para  pattern of source i on [8i+7:8i], sampled with evt[i]
//  led_para  pattern code to the LED flash controller
//  grant     one-hot source currently displayed, 0 otherwise
//  pending   latched events not yet completed
//  busy      scheduler is showing a pattern or in the gap after it
interface led_status_sched_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   evt;
    logic [8*N_REQ-1:0] evt_para;
    logic [7:0]         led_para;
    logic [N_REQ-1:0]   grant;
    logic [N_REQ-1:0]   pending;
    logic               busy;
    modport master (output evt, evt_para, input led_para, grant, pending, busy);
    modport slave (input evt, evt_para, output led_para, grant, pending, busy);
endinterface

// File: rtl/led_status_sched.sv
// led_status_sched: fixed-priority scheduler of one-shot status patterns onto a single LED para bus
//  clk      system clock
//  reset_n  asynchronous active-low reset
//  bus      led_status_sched_if slave: evt/evt_para in, led_para/grant/pending/busy out (all registered)
//  Each granted source is shown for HOLD_MS ms, then DEFAULT_PARA is driven for GAP_MS ms.
module led_status_sched #(
    parameter int         N_REQ        = 4,
    parameter int         TICK_DIV     = 100000,
    parameter int         HOLD_MS      = 2000,
    parameter int         GAP_MS       = 100,
    parameter logic [7:0] DEFAULT_PARA = 8'h00,
    parameter bit         PREEMPT      = 1'b1
) (
    input logic               clk,
    input logic               reset_n,
    led_status_sched_if.slave bus
);
    localparam int SW = N_REQ > 1 ? $clog2(N_REQ) : 1;
    localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int MW = $clog2((HOLD_MS > GAP_MS ? HOLD_MS : GAP_MS) + 1);

    typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

    state_t           state;
    logic [SW-1:0]    sel;
    logic [TW-1:0]    tick_cnt;
    logic [MW-1:0]    ms_cnt;
    logic [7:0]       para     [N_REQ];
    logic [7:0]       para_nxt [N_REQ];
    logic [N_REQ-1:0] pending_nxt;
    logic [N_REQ-1:0] lower_mask;
    logic [SW-1:0]    arb;
    logic             tick_wrap;
    logic             hold_done;
    logic             gap_done;
    logic             preempt;

    function automatic logic [SW-1:0] lowest(input logic [N_REQ-1:0] v);
        lowest = '0;
        for (int i = N_REQ - 1; i >= 0; i--)
            if (v[i]) lowest = SW'(i);
    endfunction

    // para_nxt is the value each capture register holds after this edge, so a
    // displayed pattern follows a same-edge re-trigger without an extra cycle.
    always_comb begin
        for (int i = 0; i < N_REQ; i++)
            para_nxt[i] = bus.evt[i] ? bus.evt_para[8*i +: 8] : para[i];
    end

    // The completing edge is the tick that would take ms_cnt to the limit, so
    // the dwell is exactly limit*TICK_DIV cycles and ms_cnt never reaches it.
    assign tick_wrap   = tick_cnt == TW'(TICK_DIV - 1);
    assign hold_done   = state == SHOW && tick_wrap && ms_cnt == MW'(HOLD_MS - 1);
    assign gap_done    = tick_wrap && ms_cnt == MW'(GAP_MS - 1);
    assign lower_mask  = (N_REQ'(1) << sel) - N_REQ'(1);
    assign preempt     = PREEMPT && (|(bus.pending & lower_mask));
    assign arb         = lowest(bus.pending);
    // A new event on the completing edge re-arms the source rather than being lost.
    assign pending_nxt = (bus.pending & ~(hold_done ? bus.grant : '0)) | bus.evt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            sel          <= '0;
            tick_cnt     <= '0;
            ms_cnt       <= '0;
            bus.pending  <= '0;
            bus.grant    <= '0;
            bus.led_para <= DEFAULT_PARA;
            bus.busy     <= 1'b0;
            for (int i = 0; i < N_REQ; i++)
                para[i] <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++)
                para[i] <= para_nxt[i];
            bus.pending <= pending_nxt;
            tick_cnt    <= tick_wrap ? '0 : tick_cnt + 1'b1;
            ms_cnt      <= ms_cnt + MW'(tick_wrap);
            case (state)
                IDLE: begin
                    tick_cnt <= '0;
                    ms_cnt   <= '0;
                    if (|bus.pending) begin
                        state        <= SHOW;
                        sel          <= arb;
                        bus.grant    <= N_REQ'(1) << arb;
                        bus.led_para <= para_nxt[arb];
                        bus.busy     <= 1'b1;
                    end
                end
                SHOW: begin
                    if (hold_done) begin
                        state        <= GAP_MS == 0 ? IDLE : GAP;
                        bus.grant    <= '0;
                        bus.led_para <= DEFAULT_PARA;
                        bus.busy     <= GAP_MS != 0;
                        tick_cnt     <= '0;
                        ms_cnt       <= '0;
                    end else if (preempt) begin
                        // The displaced source keeps its pending bit and restarts from scratch later.
                        sel          <= arb;
                        bus.grant    <= N_REQ'(1) << arb;
                        bus.led_para <= para_nxt[arb];
                        tick_cnt     <= '0;
                        ms_cnt       <= '0;
                    end else begin
                        bus.led_para <= para_nxt[sel];
                        if (bus.evt[sel]) begin
                            tick_cnt <= '0;
                            ms_cnt   <= '0;
                        end
                    end
                end
                GAP: begin
                    if (gap_done) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                        tick_cnt <= '0;
                        ms_cnt   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_led_status_sched.sv
// tb_led_status_sched: directed and random checks of led_status_sched against a cycle-countdown model
module tb_led_status_sched;
    localparam int HOLD_CYC = 12;
    localparam int GAP_CYC  = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    int          total = 0;
    int          bad = 0;
    int          shown;
    logic [3:0]  ev;
    logic [31:0] ep;

    int          m_mode;
    int          m_rem;
    int          m_cur;
    logic [3:0]  m_pend;
    logic [7:0]  m_para [4];

    led_status_sched_if #(.N_REQ(4)) bus ();

    led_status_sched #(
        .N_REQ(4), .TICK_DIV(4), .HOLD_MS(3), .GAP_MS(1),
        .DEFAULT_PARA(8'h00), .PREEMPT(1'b1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_rem  = 0;
        m_cur  = -1;
        m_pend = '0;
        for (int i = 0; i < 4; i++) m_para[i] = 8'h00;
    endtask

    // Mode 0 idle, 1 showing m_cur, 2 gap; m_rem counts edges left in the current phase.
    task automatic model_edge(input logic [3:0] e, input logic [31:0] p);
        int low;
        low = -1;
        for (int i = 3; i >= 0; i--) if (m_pend[i]) low = i;
        if (m_mode == 0) begin
            if (low >= 0) begin
                m_mode = 1;
                m_cur  = low;
                m_rem  = HOLD_CYC;
            end
        end else if (m_mode == 1) begin
            m_rem--;
            if (m_rem == 0) begin
                m_pend[m_cur] = 1'b0;
                m_cur  = -1;
                m_mode = GAP_CYC > 0 ? 2 : 0;
                m_rem  = GAP_CYC;
            end else if (low >= 0 && low < m_cur) begin
                m_cur = low;
                m_rem = HOLD_CYC;
            end else if (e[m_cur]) begin
                m_rem = HOLD_CYC;
            end
        end else begin
            m_rem--;
            if (m_rem == 0) m_mode = 0;
        end
        for (int i = 0; i < 4; i++)
            if (e[i]) begin
                m_pend[i] = 1'b1;
                m_para[i] = p[8*i +: 8];
            end
    endtask

    task automatic check_model();
        logic [7:0] led;
        logic [3:0] gnt;
        led = 8'h00;
        gnt = 4'b0000;
        if (m_mode == 1) begin
            led = m_para[m_cur];
            gnt = 4'(1 << m_cur);
        end
        chk("model_led_para", 32'(bus.led_para), 32'(led));
        chk("model_grant", 32'(bus.grant), 32'(gnt));
        chk("model_pending", 32'(bus.pending), 32'(m_pend));
        chk("model_busy", 32'(bus.busy), 32'(m_mode != 0));
    endtask

    task automatic step(input logic [3:0] e, input logic [31:0] p);
        bus.evt      = e;
        bus.evt_para = p;
        @(posedge clk);
        model_edge(e, p);
        #1;
        bus.evt = '0;
        check_model();
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && (m_mode != 0 || m_pend != 0); n++) step(4'b0000, 32'h0);
        chk("drain_idle", 32'(m_mode != 0 || m_pend != 0), 32'd0);
    endtask

    initial begin
        reset_n      = 1'b0;
        bus.evt      = '0;
        bus.evt_para = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_led_para", 32'(bus.led_para), 32'h00);
        chk("rst_grant", 32'(bus.grant), 32'h0);
        chk("rst_pending", 32'(bus.pending), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        #2 reset_n = 1'b1;

        // Single event on source 2
        step(4'b0100, 32'h0004_0000);
        chk("single_pending_e0", 32'(bus.pending), 32'b0100);
        chk("single_grant_e0", 32'(bus.grant), 32'b0000);
        step(4'b0000, 32'h0);
        chk("single_grant_e1", 32'(bus.grant), 32'b0100);
        chk("single_led_e1", 32'(bus.led_para), 32'h04);
        repeat (11) step(4'b0000, 32'h0);
        step(4'b0000, 32'h0);
        chk("single_led_e13", 32'(bus.led_para), 32'h00);
        chk("single_grant_e13", 32'(bus.grant), 32'b0000);
        chk("single_busy_e13", 32'(bus.busy), 32'd1);
        repeat (3) step(4'b0000, 32'h0);
        step(4'b0000, 32'h0);
        chk("single_busy_e17", 32'(bus.busy), 32'd0);
        drain();

        // Simultaneous events on sources 1 and 3
        step(4'b1010, 32'h0800_0200);
        step(4'b0000, 32'h0);
        chk("simul_grant_first", 32'(bus.grant), 32'b0010);
        chk("simul_led_first", 32'(bus.led_para), 32'h02);
        repeat (11) step(4'b0000, 32'h0);
        step(4'b0000, 32'h0);
        chk("simul_gap_grant", 32'(bus.grant), 32'b0000);
        chk("simul_gap_pending", 32'(bus.pending), 32'b1000);
        repeat (4) step(4'b0000, 32'h0);
        step(4'b0000, 32'h0);
        chk("simul_grant_second", 32'(bus.grant), 32'b1000);
        chk("simul_led_second", 32'(bus.led_para), 32'h08);
        drain();

        // Preemption of source 3 by source 0
        step(4'b1000, 32'h3000_0000);
        step(4'b0000, 32'h0);
        repeat (3) step(4'b0000, 32'h0);
        step(4'b0001, 32'h0000_0001);
        chk("preempt_pending", 32'(bus.pending), 32'b1001);
        step(4'b0000, 32'h0);
        chk("preempt_grant", 32'(bus.grant), 32'b0001);
        chk("preempt_led", 32'(bus.led_para), 32'h01);
        repeat (11) step(4'b0000, 32'h0);
        step(4'b0000, 32'h0);
        chk("preempt_done_grant", 32'(bus.grant), 32'b0000);
        repeat (4) step(4'b0000, 32'h0);
        step(4'b0000, 32'h0);
        chk("preempt_regrant", 32'(bus.grant), 32'b1000);
        chk("preempt_regrant_led", 32'(bus.led_para), 32'h30);
        repeat (11) step(4'b0000, 32'h0);
        chk("preempt_full_hold", 32'(bus.grant), 32'b1000);
        step(4'b0000, 32'h0);
        chk("preempt_final_grant", 32'(bus.grant), 32'b0000);
        chk("preempt_final_pending", 32'(bus.pending), 32'b0000);
        drain();

        // Re-trigger during SHOW and on the completing edge
        step(4'b0100, 32'h0004_0000);
        step(4'b0000, 32'h0);
        repeat (4) step(4'b0000, 32'h0);
        step(4'b0100, 32'h0008_0000);
        chk("retrig_led", 32'(bus.led_para), 32'h08);
        repeat (11) step(4'b0000, 32'h0);
        chk("retrig_still_shown", 32'(bus.grant), 32'b0100);
        step(4'b0100, 32'h000c_0000);
        chk("retrig_end_pending", 32'(bus.pending), 32'b0100);
        chk("retrig_end_grant", 32'(bus.grant), 32'b0000);
        chk("retrig_end_led", 32'(bus.led_para), 32'h00);
        repeat (4) step(4'b0000, 32'h0);
        step(4'b0000, 32'h0);
        chk("retrig_reshow_led", 32'(bus.led_para), 32'h0c);
        chk("retrig_reshow_grant", 32'(bus.grant), 32'b0100);
        drain();

        // Back-to-back events on source 1 every 20 cycles
        shown = 0;
        for (int k = 0; k < 5; k++) begin
            step(4'b0010, {16'h0, 8'($urandom_range(1, 255)), 8'h00});
            if (bus.grant === 4'b0010) shown++;
            for (int n = 0; n < 19; n++) begin
                step(4'b0000, 32'h0);
                if (bus.grant === 4'b0010) shown++;
            end
        end
        chk("b2b_shown_cycles", 32'(shown), 32'd60);
        drain();

        // Asynchronous reset in the middle of SHOW
        step(4'b0010, 32'h0000_5500);
        step(4'b0000, 32'h0);
        step(4'b0000, 32'h0);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_led_para", 32'(bus.led_para), 32'h00);
        chk("midrst_grant", 32'(bus.grant), 32'h0);
        chk("midrst_pending", 32'(bus.pending), 32'h0);
        chk("midrst_busy", 32'(bus.busy), 32'h0);
        model_reset();
        #2 reset_n = 1'b1;
        repeat (3) step(4'b0000, 32'h0);

        // Random traffic
        for (int c = 0; c < 800; c++) begin
            ev = '0;
            for (int i = 0; i < 4; i++) ev[i] = $urandom_range(15) == 0;
            ep = $urandom;
            step(ev, ep);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
